odd_parity_frame_checker: RTL and testbench

- Downstream consumer of the 4-input odd-parity stage, with inputs a, b, c, d and output y (y = a^b^c^d).
- Accepts a stream of nibbles {d,c,b,a}, each tagged with the parity bit y produced by that stage.
- Checks every tag against the nibble, accumulates parity across fixed-length frames, and reports per-frame results over a valid/ready handshake.
- Sits between the parity generator and the link-status logic.

---
 rtl/odd_parity_frame_checker.sv | 165 ++++++++++++++++
 tb/tb_odd_parity_frame_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_frame_checker.sv
// Checks upstream odd-parity tags per nibble, accumulates per-frame parity and error results,
// and reports them over valid/ready. Optional macro OFC_ERR_STICKY_EN adds err_clr/err_sticky.
module odd_parity_frame_checker #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
`ifdef OFC_ERR_STICKY_EN
   input  logic             err_clr,
   output logic             err_sticky,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_nib,
   input  logic             in_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_frame_odd,
   output logic             out_err,
   output logic [7:0]       out_err_num,
   output logic [CNT_W-1:0] err_total
);

   typedef enum logic [0:0] {COLLECT = 1'b0, REPORT = 1'b1} state_t;

   localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   function automatic logic nib_parity(input logic [3:0] nib);
      return ^nib;
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic             acc_odd_q, acc_odd_d;
   logic [7:0]       acc_err_num_q, acc_err_num_d;
   logic             res_odd_q, res_odd_d;
   logic             res_err_q, res_err_d;
   logic [7:0]       res_num_q, res_num_d;
   logic [CNT_W-1:0] err_total_q, err_total_d;

   logic             accept_s;
   logic             nib_par_s;
   logic             mismatch_s;
   logic             odd_next_s;
   logic [7:0]       err_num_next_s;

   // Per-nibble check and accumulator values including the current nibble.
   always_comb begin
      accept_s       = in_valid && (state_q == COLLECT);
      nib_par_s      = nib_parity(in_nib);
      mismatch_s     = accept_s && (nib_par_s != in_par);
      odd_next_s     = acc_odd_q ^ nib_par_s;
      err_num_next_s = acc_err_num_q + (mismatch_s ? 8'd1 : 8'd0);
   end

   // Frame FSM: collect FRAME_LEN nibbles, then hold the result until it is taken.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      acc_odd_d     = acc_odd_q;
      acc_err_num_d = acc_err_num_q;
      res_odd_d     = res_odd_q;
      res_err_d     = res_err_q;
      res_num_d     = res_num_q;
      case (state_q)
         COLLECT: begin
            if (accept_s) begin
               if (idx_q == LAST_IDX) begin
                  res_odd_d     = odd_next_s;
                  res_err_d     = (err_num_next_s != 8'd0);
                  res_num_d     = err_num_next_s;
                  idx_d         = 8'd0;
                  acc_odd_d     = 1'b0;
                  acc_err_num_d = 8'd0;
                  state_d       = REPORT;
               end else begin
                  idx_d         = idx_q + 8'd1;
                  acc_odd_d     = odd_next_s;
                  acc_err_num_d = err_num_next_s;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         REPORT: begin
            if (out_ready) begin
               state_d = COLLECT;
            end else begin
               state_d = REPORT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // Global mismatch counter saturates instead of wrapping.
   always_comb begin
      if (mismatch_s && (err_total_q != CNT_MAX)) begin
         err_total_d = err_total_q + CNT_W'(1);
      end else begin
         err_total_d = err_total_q;
      end
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= COLLECT;
         idx_q         <= 8'd0;
         acc_odd_q     <= 1'b0;
         acc_err_num_q <= 8'd0;
         res_odd_q     <= 1'b0;
         res_err_q     <= 1'b0;
         res_num_q     <= 8'd0;
         err_total_q   <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         acc_odd_q     <= acc_odd_d;
         acc_err_num_q <= acc_err_num_d;
         res_odd_q     <= res_odd_d;
         res_err_q     <= res_err_d;
         res_num_q     <= res_num_d;
         err_total_q   <= err_total_d;
      end
   end

   assign in_ready      = (state_q == COLLECT);
   assign out_valid     = (state_q == REPORT);
   assign out_frame_odd = res_odd_q;
   assign out_err       = res_err_q;
   assign out_err_num   = res_num_q;
   assign err_total     = err_total_q;

`ifdef OFC_ERR_STICKY_EN
   logic sticky_q, sticky_d;

   // A new mismatch takes priority over a clear on the same edge.
   always_comb begin
      if (mismatch_s) begin
         sticky_d = 1'b1;
      end else if (err_clr) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Sticky error flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Self-checking bench for odd_parity_frame_checker: directed frames plus random traffic,
// compared every cycle against a frame-level reference model. Covers OFC_ERR_STICKY_EN when defined.
module tb_odd_parity_frame_checker;

   localparam int FRAME_LEN = 8;
   localparam int CNT_W     = 4;
   localparam longint CNT_MAXV = (64'd1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_nib;
   logic             in_par;
   logic             out_valid;
   logic             out_ready;
   logic             out_frame_odd;
   logic             out_err;
   logic [7:0]       out_err_num;
   logic [CNT_W-1:0] err_total;
`ifdef OFC_ERR_STICKY_EN
   logic             err_clr;
   logic             err_sticky;
   bit               m_sticky;
`endif

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   int     m_cnt, m_mis;
   bit     m_odd, m_pend;
   bit     r_odd, r_err;
   int     r_num;
   longint m_total;

   odd_parity_frame_checker #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
`ifdef OFC_ERR_STICKY_EN
      .err_clr(err_clr),
      .err_sticky(err_sticky),
`endif
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_nib(in_nib),
      .in_par(in_par),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_frame_odd(out_frame_odd),
      .out_err(out_err),
      .out_err_num(out_err_num),
      .err_total(err_total)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ones_parity(input logic [3:0] nib);
      return bit'($countones(nib) % 2);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_mis = 0; m_odd = 0; m_pend = 0;
      r_odd = 0; r_err = 0; r_num = 0; m_total = 0;
`ifdef OFC_ERR_STICKY_EN
      m_sticky = 0;
`endif
   endtask

   // One clock: drive inputs, advance the model on the edge, compare all outputs.
   task automatic cycle(input bit v, input logic [3:0] nib, input bit par, input bit ordy,
                        input bit rs, input bit clr, output bit acc);
      bit mis, p;
      in_valid = v; in_nib = nib; in_par = par; out_ready = ordy; rst = rs;
`ifdef OFC_ERR_STICKY_EN
      err_clr = clr;
`endif
      acc = 0;
      @(posedge clk);
      #1;
      if (rs) begin
         model_reset();
      end else begin
         acc = v && !m_pend;
         p   = ones_parity(nib);
         mis = acc && (p != par);
         if (m_pend && ordy) m_pend = 0;
         if (acc) begin
            m_cnt++;
            m_odd ^= p;
            if (mis) begin
               m_mis++;
               m_total++;
            end
            if (m_cnt == FRAME_LEN) begin
               r_odd = m_odd; r_num = m_mis; r_err = (m_mis != 0); m_pend = 1;
               m_cnt = 0; m_odd = 0; m_mis = 0;
            end
         end
`ifdef OFC_ERR_STICKY_EN
         if (mis) m_sticky = 1;
         else if (clr) m_sticky = 0;
`else
         if (clr) p = p;
`endif
      end
      check_eq("in_ready", in_ready, !m_pend);
      check_eq("out_valid", out_valid, m_pend);
      check_eq("out_frame_odd", out_frame_odd, r_odd);
      check_eq("out_err", out_err, r_err);
      check_eq("out_err_num", out_err_num, r_num);
      check_eq("err_total", err_total, (m_total > CNT_MAXV) ? CNT_MAXV : m_total);
`ifdef OFC_ERR_STICKY_EN
      check_eq("err_sticky", err_sticky, m_sticky);
`endif
   endtask

   task automatic send_nib(input logic [3:0] nib, input bit par, input bit ordy);
      bit acc;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, nib, par, ordy, 1'b0, 1'b0, acc);
         if (acc) return;
      end
      check_eq("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, ordy, 1'b0, 1'b0, acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      bit acc;
      logic [3:0] nib;
      model_reset();
      // reset state
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
      idle(1, 1'b1);

      // clean frame 0..7
      for (int i = 0; i < FRAME_LEN; i++) send_nib(4'(i), ones_parity(4'(i)), 1'b1);
      check_eq("t1_valid", out_valid, 1'b1);
      check_eq("t1_odd", out_frame_odd, 1'b0);
      check_eq("t1_num", out_err_num, 8'd0);
      idle(1, 1'b1);

      // tags on 0x1 and 0x6 inverted
      for (int i = 0; i < FRAME_LEN; i++)
         send_nib(4'(i), ones_parity(4'(i)) ^ ((i == 1) || (i == 6)), 1'b1);
      check_eq("t2_err", out_err, 1'b1);
      check_eq("t2_num", out_err_num, 8'd2);
      check_eq("t2_total", err_total, 4'd2);

      // backpressure: in_valid held while result is not taken
      for (int i = 0; i < 5; i++) cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      check_eq("t3_stable_num", out_err_num, 8'd2);

      // 7x 0xF + 0x1 gives odd frame parity
      for (int i = 0; i < FRAME_LEN - 1; i++) send_nib(4'hF, 1'b0, 1'b1);
      send_nib(4'h1, 1'b1, 1'b1);
      check_eq("t4_odd", out_frame_odd, 1'b1);
      idle(1, 1'b1);

      // reset mid-frame with one mismatch
      send_nib(4'h2, 1'b1, 1'b1);
      send_nib(4'h3, 1'b1, 1'b1);
      send_nib(4'h4, 1'b1, 1'b1);
      send_nib(4'h5, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
      check_eq("t5_total", err_total, 4'd0);
      check_eq("t5_ready", in_ready, 1'b1);
      for (int i = 0; i < FRAME_LEN; i++) send_nib(4'(i + 8), ones_parity(4'(i + 8)), 1'b1);
      check_eq("t5_num", out_err_num, 8'd0);
      idle(1, 1'b1);

`ifdef OFC_ERR_STICKY_EN
      // sticky: set, clear, clear versus simultaneous mismatch
      send_nib(4'h7, 1'b0, 1'b1);
      check_eq("t6_set", err_sticky, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      check_eq("t6_clr", err_sticky, 1'b0);
      cycle(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      check_eq("t6_set_wins", err_sticky, 1'b1);
      idle(2, 1'b1);
`endif

      // saturation: a run of mismatches beyond the counter range
      for (int i = 0; i < 20; i++) begin
         nib = 4'($urandom_range(0, 15));
         send_nib(nib, !ones_parity(nib), 1'b1);
      end
      check_eq("t7_saturated", err_total, 4'hF);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         nib = 4'($urandom_range(0, 15));
         cycle(($urandom % 4) != 0, nib, ones_parity(nib) ^ (($urandom % 4) == 0),
               ($urandom % 3) != 0, ($urandom % 150) == 0, ($urandom % 16) == 0, acc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
